// File: rtl/aidc_pkg.sv
// Shared types and helpers for the AIDC write-stream arbiter.
// Holds the arbiter state encoding and the channel-index width helper.
package aidc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK  = 2'd1,
      DRAIN = 2'd2
   } arb_state_t;

   // A single channel still needs a one-bit index so ch_o never collapses to zero width.
   function automatic int ch_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/aidc_rr_pick.sv
// Combinational round-robin priority picker.
// Returns the first asserted request at or after ptr, wrapping at NUM_CH.
module aidc_rr_pick
   import aidc_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   idx,
   output logic              any
);

   always_comb begin
      int cand;
      cand = 0;
      idx  = '0;
      any  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         cand = (int'(ptr) + i) % NUM_CH;
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = CH_W'(cand);
         end
      end
   end

endmodule

// File: rtl/aidc_wr_arb.sv
// Burst-granular round-robin merge of NUM_CH write beat streams into one stream,
// with SOP generation, channel/bypass tagging and max-length truncate-and-drain.
module aidc_wr_arb
   import aidc_pkg::*;
#(
   parameter  int NUM_CH    = 2,
   parameter  int DATA_W    = 512,
   parameter  int MAX_BEATS = 4,
   localparam int CH_W      = ch_width(NUM_CH),
   localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              valid_i,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  data_i,
   input  logic [NUM_CH-1:0]              last_i,
   input  logic [NUM_CH-1:0]              bypass_i,
   output logic [NUM_CH-1:0]              ready_o,
   output logic                           valid_o,
   output logic [DATA_W-1:0]              data_o,
   output logic                           sop_o,
   output logic                           eop_o,
   output logic [CH_W-1:0]                ch_o,
   output logic                           bypass_o,
   input  logic                           ready_i,
   output logic                           len_err_o,
   output logic                           busy_o
);

   localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_BEATS);

   arb_state_t        state, state_d;
   logic [CH_W-1:0]   rr_ptr, rr_ptr_d;
   logic [CH_W-1:0]   owner, owner_d;
   logic [CNT_W-1:0]  beat_cnt, beat_cnt_d;
   logic              bypass_q, bypass_d;
   logic              len_err_q, len_err_d;
   logic [CH_W-1:0]   pick;
   logic              any_req;
   logic [CNT_W:0]    cnt_inc;
   logic              at_limit;

   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
      if (c == CH_W'(NUM_CH - 1))
         return '0;
      return c + CH_W'(1);
   endfunction

   aidc_rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_pick (
      .req (valid_i),
      .ptr (rr_ptr),
      .idx (pick),
      .any (any_req)
   );

   // Count the beat being offered now; a first beat always counts as one.
   assign cnt_inc  = ((state == IDLE) ? '0 : {1'b0, beat_cnt}) + (CNT_W + 1)'(1);
   assign at_limit = (cnt_inc >= MAX_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         owner     <= '0;
         beat_cnt  <= '0;
         bypass_q  <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state     <= state_d;
         rr_ptr    <= rr_ptr_d;
         owner     <= owner_d;
         beat_cnt  <= beat_cnt_d;
         bypass_q  <= bypass_d;
         len_err_q <= len_err_d;
      end
   end

   always_comb begin
      state_d    = state;
      rr_ptr_d   = rr_ptr;
      owner_d    = owner;
      beat_cnt_d = beat_cnt;
      bypass_d   = bypass_q;
      len_err_d  = 1'b0;
      case (state)
         IDLE: begin
            if (any_req && ready_i) begin
               if (last_i[pick]) begin
                  rr_ptr_d = next_ch(pick);
               end else begin
                  owner_d    = pick;
                  bypass_d   = bypass_i[pick];
                  beat_cnt_d = cnt_inc[CNT_W-1:0];
                  if (at_limit) begin
                     state_d   = DRAIN;
                     len_err_d = 1'b1;
                  end else begin
                     state_d = LOCK;
                  end
               end
            end
         end
         LOCK: begin
            if (valid_i[owner] && ready_i) begin
               beat_cnt_d = cnt_inc[CNT_W-1:0];
               // A last beat landing exactly on MAX_BEATS is a legal burst, not a truncation.
               if (last_i[owner]) begin
                  state_d    = IDLE;
                  rr_ptr_d   = next_ch(owner);
                  beat_cnt_d = '0;
               end else if (at_limit) begin
                  state_d   = DRAIN;
                  len_err_d = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (valid_i[owner] && last_i[owner]) begin
               state_d    = IDLE;
               rr_ptr_d   = next_ch(owner);
               beat_cnt_d = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are forced low during reset even though the data path is combinational.
   always_comb begin
      valid_o  = 1'b0;
      ready_o  = '0;
      data_o   = '0;
      sop_o    = 1'b0;
      eop_o    = 1'b0;
      ch_o     = '0;
      bypass_o = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               ch_o   = pick;
               data_o = data_i[pick];
               if (any_req) begin
                  valid_o       = 1'b1;
                  sop_o         = 1'b1;
                  eop_o         = last_i[pick] || at_limit;
                  bypass_o      = bypass_i[pick];
                  ready_o[pick] = ready_i;
               end
            end
            LOCK: begin
               ch_o           = owner;
               data_o         = data_i[owner];
               valid_o        = valid_i[owner];
               eop_o          = last_i[owner] || at_limit;
               bypass_o       = bypass_q;
               ready_o[owner] = ready_i;
            end
            DRAIN: begin
               ch_o           = owner;
               bypass_o       = bypass_q;
               ready_o[owner] = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign len_err_o = len_err_q;
   assign busy_o    = (state == LOCK) || (state == DRAIN);

endmodule

// File: tb/tb_aidc_wr_arb.sv
// Scoreboard bench for aidc_wr_arb: per-channel source queues feed the DUT,
// expected merged beats are queued by each scenario and compared as they appear.
module tb_aidc_wr_arb;

   localparam int NUM_CH    = 2;
   localparam int DATA_W    = 32;
   localparam int MAX_BEATS = 4;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic [NUM_CH-1:0]             valid_i;
   logic [NUM_CH-1:0][DATA_W-1:0] data_i;
   logic [NUM_CH-1:0]             last_i;
   logic [NUM_CH-1:0]             bypass_i;
   logic [NUM_CH-1:0]             ready_o;
   logic                          valid_o;
   logic [DATA_W-1:0]             data_o;
   logic                          sop_o;
   logic                          eop_o;
   logic [0:0]                    ch_o;
   logic                          bypass_o;
   logic                          ready_i = 1'b1;
   logic                          len_err_o;
   logic                          busy_o;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      logic              byp;
   } src_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
      logic [0:0]        ch;
      logic              byp;
      logic              trunc;
   } exp_t;

   src_t src0_q[$];
   src_t src1_q[$];
   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   logic len_exp = 1'b0;

   aidc_wr_arb #(
      .NUM_CH    (NUM_CH),
      .DATA_W    (DATA_W),
      .MAX_BEATS (MAX_BEATS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i),
      .data_i    (data_i),
      .last_i    (last_i),
      .bypass_i  (bypass_i),
      .ready_o   (ready_o),
      .valid_o   (valid_o),
      .data_o    (data_o),
      .sop_o     (sop_o),
      .eop_o     (eop_o),
      .ch_o      (ch_o),
      .bypass_o  (bypass_o),
      .ready_i   (ready_i),
      .len_err_o (len_err_o),
      .busy_o    (busy_o)
   );

   always #5 clk = ~clk;

   task automatic drive_inputs();
      valid_i  = '0;
      last_i   = '0;
      bypass_i = '0;
      data_i   = '0;
      if (src0_q.size() != 0) begin
         valid_i[0]  = 1'b1;
         data_i[0]   = src0_q[0].data;
         last_i[0]   = src0_q[0].last;
         bypass_i[0] = src0_q[0].byp;
      end
      if (src1_q.size() != 0) begin
         valid_i[1]  = 1'b1;
         data_i[1]   = src1_q[0].data;
         last_i[1]   = src1_q[0].last;
         bypass_i[1] = src1_q[0].byp;
      end
   endtask

   // Bypass is driven only on the first beat; later beats carry the inverse to prove it is ignored.
   task automatic add_src(input int ch, input int n, input logic [DATA_W-1:0] base, input logic byp);
      src_t s;
      for (int i = 0; i < n; i++) begin
         s.data = base + DATA_W'(i);
         s.last = (i == n - 1);
         s.byp  = (i == 0) ? byp : ~byp;
         if (ch == 0) src0_q.push_back(s);
         else         src1_q.push_back(s);
      end
   endtask

   task automatic add_exp(input int ch, input int n, input logic [DATA_W-1:0] base,
                          input logic byp, input logic trunc);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.data  = base + DATA_W'(i);
         e.sop   = (i == 0);
         e.eop   = (i == n - 1);
         e.ch    = 1'(ch);
         e.byp   = byp;
         e.trunc = trunc && (i == n - 1);
         exp_q.push_back(e);
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (src0_q.size() == 0 && src1_q.size() == 0 && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_exp_left(input int left, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #2;
         if (exp_q.size() == left) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Source driver: handshakes are decided mid-cycle, queues advance just after the edge.
   initial begin
      logic hs0, hs1;
      drive_inputs();
      forever begin
         @(negedge clk);
         hs0 = valid_i[0] & ready_o[0];
         hs1 = valid_i[1] & ready_o[1];
         @(posedge clk); #1;
         if (hs0 && src0_q.size() != 0) void'(src0_q.pop_front());
         if (hs1 && src1_q.size() != 0) void'(src1_q.pop_front());
         drive_inputs();
      end
   end

   // Output monitor: every accepted merged beat must match the head of the expected queue.
   initial begin
      exp_t e;
      logic pend;
      forever begin
         @(negedge clk);
         checks++;
         if (len_err_o !== len_exp) begin
            errors++;
            $display("[TB] FAIL len_err: got %b want %b at %0t", len_err_o, len_exp, $time);
         end
         pend = 1'b0;
         if (valid_o === 1'b1 && ready_i === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL beat_unexpected: got ch=%0d data=%h want none", ch_o, data_o);
            end else begin
               e = exp_q.pop_front();
               if (data_o !== e.data || sop_o !== e.sop || eop_o !== e.eop ||
                   ch_o !== e.ch || bypass_o !== e.byp) begin
                  errors++;
                  $display("[TB] FAIL beat: got data=%h sop=%b eop=%b ch=%0d byp=%b want data=%h sop=%b eop=%b ch=%0d byp=%b",
                           data_o, sop_o, eop_o, ch_o, bypass_o, e.data, e.sop, e.eop, e.ch, e.byp);
               end
               pend = e.trunc;
            end
         end
         len_exp = rst ? 1'b0 : pend;
      end
   end

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      checks++; if (valid_o !== 1'b0)   begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid_o); end
      checks++; if (ready_o !== 2'b00)  begin errors++; $display("[TB] FAIL reset_ready: got %b want 00", ready_o); end
      checks++; if (sop_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset_sop: got %b want 0", sop_o); end
      checks++; if (eop_o !== 1'b0)     begin errors++; $display("[TB] FAIL reset_eop: got %b want 0", eop_o); end
      checks++; if (len_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_len_err: got %b want 0", len_err_o); end
      checks++; if (busy_o !== 1'b0)    begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
      rst = 1'b0;
      @(posedge clk); #2;
      checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b want 0", busy_o); end
   endtask

   task automatic test_single_burst();
      bit ok;
      @(posedge clk); #2;
      add_src(0, 4, 32'hA000_0000, 1'b0);
      add_exp(0, 4, 32'hA000_0000, 1'b0, 1'b0);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL single_timeout: got pending=%0d want 0", exp_q.size()); end
      repeat (2) @(posedge clk);
   endtask

   // Pointer sits at ch1 after the previous ch0 burst, so ch1 leads the rotation.
   task automatic test_round_robin();
      bit ok;
      @(posedge clk); #2;
      add_src(0, 2, 32'hB000_0000, 1'b0);
      add_src(0, 2, 32'hB000_0100, 1'b0);
      add_src(1, 2, 32'hB001_0000, 1'b0);
      add_src(1, 2, 32'hB001_0100, 1'b1);
      add_exp(1, 2, 32'hB001_0000, 1'b0, 1'b0);
      add_exp(0, 2, 32'hB000_0000, 1'b0, 1'b0);
      add_exp(1, 2, 32'hB001_0100, 1'b1, 1'b0);
      add_exp(0, 2, 32'hB000_0100, 1'b0, 1'b0);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rr_timeout: got pending=%0d want 0", exp_q.size()); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_bypass_hold();
      bit ok;
      @(posedge clk); #2;
      add_src(1, 3, 32'hC001_0000, 1'b1);
      add_exp(1, 3, 32'hC001_0000, 1'b1, 1'b0);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL bypass_timeout: got pending=%0d want 0", exp_q.size()); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_truncation();
      bit ok;
      @(posedge clk); #2;
      add_src(0, 6, 32'hD000_0000, 1'b0);
      add_src(1, 2, 32'hD001_0000, 1'b1);
      add_exp(0, 4, 32'hD000_0000, 1'b0, 1'b1);
      add_exp(1, 2, 32'hD001_0000, 1'b1, 1'b0);
      wait_exp_left(2, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL trunc_head_timeout: got pending=%0d want 2", exp_q.size()); end
      checks++; if (busy_o !== 1'b1)  begin errors++; $display("[TB] FAIL drain_busy: got %b want 1", busy_o); end
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL drain_valid: got %b want 0", valid_o); end
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL trunc_timeout: got pending=%0d want 0", exp_q.size()); end
      repeat (2) @(posedge clk);
   endtask

   task automatic test_backpressure();
      bit ok;
      @(posedge clk); #2;
      add_src(0, 4, 32'hE000_0000, 1'b0);
      add_exp(0, 4, 32'hE000_0000, 1'b0, 1'b0);
      wait_exp_left(2, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_head_timeout: got pending=%0d want 2", exp_q.size()); end
      ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (valid_o !== 1'b1)  begin errors++; $display("[TB] FAIL bp_valid: got %b want 1", valid_o); end
         checks++; if (ready_o !== 2'b00) begin errors++; $display("[TB] FAIL bp_ready: got %b want 00", ready_o); end
         checks++; if (data_o !== 32'hE000_0002) begin errors++; $display("[TB] FAIL bp_data: got %h want e0000002", data_o); end
         checks++; if (busy_o !== 1'b1)   begin errors++; $display("[TB] FAIL bp_busy: got %b want 1", busy_o); end
      end
      @(posedge clk); #2;
      ready_i = 1'b1;
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: got pending=%0d want 0", exp_q.size()); end
      repeat (2) @(posedge clk);
   endtask

   // Pointer is at ch1 before the reset, so ch0 winning afterwards shows rr_ptr was cleared.
   task automatic test_reset_mid_burst();
      bit ok;
      @(posedge clk); #2;
      add_src(0, 4, 32'hF000_0000, 1'b0);
      add_exp(0, 4, 32'hF000_0000, 1'b0, 1'b0);
      wait_exp_left(2, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_head_timeout: got pending=%0d want 2", exp_q.size()); end
      #1 rst = 1'b1;
      #1;
      checks++; if (valid_o !== 1'b0)   begin errors++; $display("[TB] FAIL rst_mid_valid: got %b want 0", valid_o); end
      checks++; if (ready_o !== 2'b00)  begin errors++; $display("[TB] FAIL rst_mid_ready: got %b want 00", ready_o); end
      checks++; if (sop_o !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_sop: got %b want 0", sop_o); end
      checks++; if (eop_o !== 1'b0)     begin errors++; $display("[TB] FAIL rst_mid_eop: got %b want 0", eop_o); end
      checks++; if (len_err_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_len_err: got %b want 0", len_err_o); end
      checks++; if (busy_o !== 1'b0)    begin errors++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy_o); end
      src0_q.delete();
      exp_q.delete();
      @(posedge clk); #2;
      rst = 1'b0;
      @(posedge clk); #2;
      add_src(1, 2, 32'hF001_0000, 1'b1);
      add_src(0, 1, 32'hF000_0100, 1'b0);
      add_exp(0, 1, 32'hF000_0100, 1'b0, 1'b0);
      add_exp(1, 2, 32'hF001_0000, 1'b1, 1'b0);
      wait_idle(ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL rst_after_timeout: got pending=%0d want 0", exp_q.size()); end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      $display("[TB] aidc_wr_arb bench start");
      test_reset();
      test_single_burst();
      test_round_robin();
      test_bypass_hold();
      test_truncation();
      test_backpressure();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
